// File: rtl/la_pdfd_pkg.sv
// Shared types, slicer thresholds and symbol helpers for the PAM-5 look-ahead DFE.
package la_pdfd_pkg;

    localparam int unsigned Lanes = 4;
    localparam int unsigned NTaps = 14;
    localparam int unsigned SW    = 8;
    localparam int          Level = 32;
    // 14 bits covers |sample| + 14 * 128 * 2 with margin.
    localparam int unsigned EqW   = 14;

    typedef logic signed [2:0]     sym_t;
    typedef logic signed [EqW-1:0] eq_t;

    localparam eq_t ThLo = eq_t'(Level / 2);
    localparam eq_t ThHi = eq_t'(Level + Level / 2);

    function automatic sym_t slice(input eq_t eq);
        if (eq >= ThHi)       return sym_t'(2);
        else if (eq >= ThLo)  return sym_t'(1);
        else if (eq > -ThLo)  return sym_t'(0);
        else if (eq > -ThHi)  return sym_t'(-1);
        else                  return sym_t'(-2);
    endfunction

    // bit1 = sign, bit0 = outer level.
    function automatic logic [1:0] sym_bits(input sym_t d);
        return {d[2], (d == sym_t'(2)) || (d == sym_t'(-2))};
    endfunction

endpackage

// File: rtl/la_pdfd_lane.sv
// One lane: decision history, look-ahead ISI cancellation and PAM-5 slicer.
module la_pdfd_lane
    import la_pdfd_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic signed [SW-1:0] sample_i,
    input  logic signed [SW-1:0] taps_i [NTaps],
    output sym_t                 sym_o,
    output logic [1:0]           bits_o
);

    sym_t h_q [NTaps];
    sym_t h_d [NTaps];
    eq_t  partial;
    eq_t  cand [5];
    eq_t  isi;
    eq_t  eq;

    always_comb begin
        partial = '0;
        for (int k = 1; k < NTaps; k++) begin
            partial = partial + eq_t'(taps_i[k]) * eq_t'(h_q[k]);
        end
        // Newest-tap term precomputed for every possible h[0], then selected.
        for (int j = 0; j < 5; j++) begin
            cand[j] = partial + eq_t'(taps_i[0]) * eq_t'(j - 2);
        end
        case (h_q[0])
            sym_t'(-2): isi = cand[0];
            sym_t'(-1): isi = cand[1];
            sym_t'(1):  isi = cand[3];
            sym_t'(2):  isi = cand[4];
            default:    isi = cand[2];
        endcase
        eq     = eq_t'(sample_i) - isi;
        sym_o  = slice(eq);
        bits_o = sym_bits(sym_o);
        h_d[0] = sym_o;
        for (int k = 1; k < NTaps; k++) begin
            h_d[k] = h_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NTaps; k++) begin
                h_q[k] <= '0;
            end
        end else begin
            h_q <= h_d;
        end
    end

endmodule

// File: rtl/la_pdfd.sv
// Four-lane look-ahead decision-feedback decoder packing PAM-5 decisions into bytes.
module la_pdfd
    import la_pdfd_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic signed [7:0] io_rxSamples_0,
    input  logic signed [7:0] io_rxSamples_1,
    input  logic signed [7:0] io_rxSamples_2,
    input  logic signed [7:0] io_rxSamples_3,
    input  logic signed [7:0] io_taps_0,
    input  logic signed [7:0] io_taps_1,
    input  logic signed [7:0] io_taps_2,
    input  logic signed [7:0] io_taps_3,
    input  logic signed [7:0] io_taps_4,
    input  logic signed [7:0] io_taps_5,
    input  logic signed [7:0] io_taps_6,
    input  logic signed [7:0] io_taps_7,
    input  logic signed [7:0] io_taps_8,
    input  logic signed [7:0] io_taps_9,
    input  logic signed [7:0] io_taps_10,
    input  logic signed [7:0] io_taps_11,
    input  logic signed [7:0] io_taps_12,
    input  logic signed [7:0] io_taps_13,
    output logic [7:0]        io_rxData,
    output logic              io_rxValid
);

    logic signed [SW-1:0] taps    [NTaps];
    logic signed [SW-1:0] samples [Lanes];
    sym_t                 sym     [Lanes];
    logic [1:0]           bits    [Lanes];
    logic [7:0]           data_d, data_q;
    logic                 valid_d, valid_q;

    assign taps = '{io_taps_0, io_taps_1, io_taps_2, io_taps_3, io_taps_4, io_taps_5,
                    io_taps_6, io_taps_7, io_taps_8, io_taps_9, io_taps_10, io_taps_11,
                    io_taps_12, io_taps_13};
    assign samples = '{io_rxSamples_0, io_rxSamples_1, io_rxSamples_2, io_rxSamples_3};

    for (genvar i = 0; i < Lanes; i++) begin : g_lane
        la_pdfd_lane u_lane (
            .clock    (clock),
            .reset    (reset),
            .sample_i (samples[i]),
            .taps_i   (taps),
            .sym_o    (sym[i]),
            .bits_o   (bits[i])
        );
    end

    always_comb begin
        data_d  = '0;
        valid_d = 1'b1;
        for (int i = 0; i < Lanes; i++) begin
            data_d[2*i +: 2] = bits[i];
            if (sym[i] == sym_t'(0)) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign io_rxData  = data_q;
    assign io_rxValid = valid_q;

endmodule

// File: tb/tb_la_pdfd.sv
// Directed plan plus randomized traffic checked against an integer DFE model.
module tb_la_pdfd;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic signed [7:0] smp [4];
    logic signed [7:0] tp  [14];
    logic [7:0]        rx_data;
    logic              rx_valid;

    int checks = 0;
    int errors = 0;
    int hist [4][14];
    int exp_data;
    int exp_valid;

    always #5 clock = ~clock;

    la_pdfd dut (
        .clock          (clock),
        .reset          (reset),
        .io_rxSamples_0 (smp[0]),
        .io_rxSamples_1 (smp[1]),
        .io_rxSamples_2 (smp[2]),
        .io_rxSamples_3 (smp[3]),
        .io_taps_0      (tp[0]),
        .io_taps_1      (tp[1]),
        .io_taps_2      (tp[2]),
        .io_taps_3      (tp[3]),
        .io_taps_4      (tp[4]),
        .io_taps_5      (tp[5]),
        .io_taps_6      (tp[6]),
        .io_taps_7      (tp[7]),
        .io_taps_8      (tp[8]),
        .io_taps_9      (tp[9]),
        .io_taps_10     (tp[10]),
        .io_taps_11     (tp[11]),
        .io_taps_12     (tp[12]),
        .io_taps_13     (tp[13]),
        .io_rxData      (rx_data),
        .io_rxValid     (rx_valid)
    );

    function automatic int decide(input int eq);
        if (eq >= 48) return 2;
        if (eq >= 16) return 1;
        if (eq > -16) return 0;
        if (eq > -48) return -1;
        return -2;
    endfunction

    function automatic int code(input int d);
        int b = 0;
        if (d < 0) b += 2;
        if (d == 2 || d == -2) b += 1;
        return b;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Apply one edge; the model advances and the registered outputs are compared.
    task automatic step(input int s0, input int s1, input int s2, input int s3,
                        input bit rst);
        int s [4];
        s = '{s0, s1, s2, s3};
        reset = rst;
        for (int i = 0; i < 4; i++) smp[i] = 8'(s[i]);
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 14; k++) hist[i][k] = 0;
            exp_data  = 0;
            exp_valid = 0;
        end else begin
            exp_data  = 0;
            exp_valid = 1;
            for (int i = 0; i < 4; i++) begin
                int isi = 0;
                int d;
                for (int k = 0; k < 14; k++) isi += int'(tp[k]) * hist[i][k];
                d = decide(s[i] - isi);
                if (d == 0) exp_valid = 0;
                exp_data += code(d) << (2 * i);
                for (int k = 13; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = d;
            end
        end
        #1;
        chk("model_data", int'(rx_data), exp_data);
        chk("model_valid", int'(rx_valid), exp_valid);
        @(negedge clock);
    endtask

    task automatic set_taps(input int t0, input int t13);
        for (int k = 0; k < 14; k++) tp[k] = 8'sd0;
        tp[0]  = 8'(t0);
        tp[13] = 8'(t13);
    endtask

    initial begin
        set_taps(0, 0);
        for (int i = 0; i < 4; i++) smp[i] = 8'(i * 37);
        @(negedge clock);

        // 1: reset and zero-sample behaviour
        step(99, -7, 3, 120, 1'b1);
        step(-5, 64, 0, 17, 1'b1);
        chk("reset_data", int'(rx_data), 8'h00);
        chk("reset_valid", int'(rx_valid), 0);
        step(0, 0, 0, 0, 1'b0);
        chk("zero_valid", int'(rx_valid), 0);

        // 2: ideal levels and upper thresholds
        step(64, 32, -32, -64, 1'b0);
        chk("levels_data", int'(rx_data), 8'hE1);
        chk("levels_valid", int'(rx_valid), 1);
        step(48, 47, 16, 15, 1'b0);
        chk("thr_hi_data", int'(rx_data), 8'h01);
        chk("thr_hi_valid", int'(rx_valid), 0);

        // 3: lower thresholds
        step(-16, -17, -48, -49, 1'b0);
        chk("thr_lo_data", int'(rx_data), 8'hFA);
        chk("thr_lo_valid", int'(rx_valid), 1);

        // 4: newest-tap feedback
        step(0, 0, 0, 0, 1'b1);
        set_taps(16, 0);
        step(64, 64, 64, 64, 1'b0);
        chk("fb_first", int'(rx_data), 8'h55);
        step(64, 64, 64, 64, 1'b0);
        chk("fb_second", int'(rx_data), 8'h00);
        chk("fb_valid", int'(rx_valid), 1);

        // 5: deepest tap
        step(0, 0, 0, 0, 1'b1);
        set_taps(0, 16);
        step(64, 64, 64, 64, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            step(32, 32, 32, 32, 1'b0);
            chk("deep_data", int'(rx_data), 8'h00);
            chk("deep_valid", int'(rx_valid), 1);
        end
        step(32, 32, 32, 32, 1'b0);
        chk("deep_cyc14_valid", int'(rx_valid), 0);

        // 6: reset between the two feedback samples clears history
        step(0, 0, 0, 0, 1'b1);
        set_taps(16, 0);
        step(64, 64, 64, 64, 1'b0);
        step(64, 64, 64, 64, 1'b1);
        step(64, 64, 64, 64, 1'b0);
        chk("rst_hist_data", int'(rx_data), 8'h55);
        chk("rst_hist_valid", int'(rx_valid), 1);

        // Randomized traffic with changing taps and occasional reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 14; k++)
                    tp[k] = 8'($signed($urandom_range(0, 40)) - 20);
                if ($urandom_range(0, 3) == 0) tp[$urandom_range(0, 13)] = 8'($urandom);
            end
            step($signed($urandom_range(0, 255)) - 128, $signed($urandom_range(0, 160)) - 80,
                 $signed($urandom_range(0, 255)) - 128, $signed($urandom_range(0, 160)) - 80,
                 $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
